// File: rtl/hpdmc_burst_datapath_pkg.sv
// Shared definitions for the HPDMC burst datapath: write-issue FSM state
// encodings and the helper that derives pointer widths from the geometry.
package hpdmc_burst_datapath_pkg;

  typedef enum logic {
    W_IDLE = 1'b0,
    W_RUN  = 1'b1
  } w_state_t;

  // Pointer width for an index over n entries (never narrower than one bit).
  function automatic int ptr_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/hpdmc_burst_slots.sv
// NSLOT x BURST register array with one write port (optionally filling the
// rest of the addressed slot), one combinational read port and a count of
// occupied slots. Contents are never reset; only the count is.
module hpdmc_burst_slots
  import hpdmc_burst_datapath_pkg::*;
#(
  parameter int W     = 8,
  parameter int BURST = 4,
  parameter int NSLOT = 2,
  localparam int PW   = ptr_w(NSLOT),
  localparam int IW   = ptr_w(BURST),
  localparam int CW   = PW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [PW-1:0] wslot,
  input  logic [IW-1:0] widx,
  input  logic [W-1:0]  wdat,
  input  logic          wfill,
  input  logic [W-1:0]  fill_dat,
  input  logic [PW-1:0] rslot,
  input  logic [IW-1:0] ridx,
  output logic [W-1:0]  rdat,
  input  logic          inc,
  input  logic          dec,
  output logic [CW-1:0] count
);

  logic [W-1:0] mem [NSLOT][BURST];

  // Storage: write the addressed word; with wfill, every other word of the slot gets fill_dat.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < BURST; b++) begin
        if (IW'(b) == widx) mem[wslot][b] <= wdat;
        else if (wfill)     mem[wslot][b] <= fill_dat;
      end
    end
  end

  assign rdat = mem[rslot][ridx];

  // Occupancy: simultaneous inc and dec cancel.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)              count <= '0;
    else if (inc && !dec) count <= count + 1'b1;
    else if (dec && !inc) count <= count - 1'b1;
  end

endmodule

// File: rtl/hpdmc_burst_datapath.sv
// HPDMC burst datapath: buffers committed write bursts (data + byte mask) and
// streams them to an SDR PHY, and collects read bursts from the PHY into slots
// for the bus side.
// Optional error flags are built when HPDMC_BURST_DATAPATH_ERR_EN is defined.
//
// Handshake semantics: the PHY side has no backpressure. phy_wr_valid marks a
// word the PHY must take that cycle; phy_rd_valid marks a word the datapath
// takes that cycle (or drops as part of an overflowed burst). Bus-side strobes
// (next/nextburst/commit) act in the cycle they are high.
module hpdmc_burst_datapath
  import hpdmc_burst_datapath_pkg::*;
#(
  parameter int DW    = 64,
  parameter int BURST = 4,
  parameter int NSLOT = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            buffer_w_nextburst,
  input  logic            buffer_w_next,
  input  logic [DW/8-1:0] buffer_w_mask,
  input  logic [DW-1:0]   buffer_w_dat,
  input  logic            buffer_w_commit,
  output logic            buffer_w_full,
  input  logic            op_write,
  output logic            phy_wr_valid,
  output logic [DW-1:0]   phy_wr_dat,
  output logic [DW/8-1:0] phy_wr_mask,
  input  logic            phy_rd_valid,
  input  logic [DW-1:0]   phy_rd_dat,
  output logic            buffer_r_ready,
  input  logic            buffer_r_next,
  input  logic            buffer_r_nextburst,
  output logic [DW-1:0]   buffer_r_dat,
`ifdef HPDMC_BURST_DATAPATH_ERR_EN
  output logic            err_w_underflow,
  output logic            err_r_overflow,
  input  logic            err_clear,
`endif
  output logic            w_state_dbg
);

  localparam int MW = DW / 8;
  localparam int WW = DW + MW;
  localparam int PW = ptr_w(NSLOT);
  localparam int IW = ptr_w(BURST);
  localparam int CW = PW + 1;

  // ---------------- write side ----------------
  logic [CW-1:0] w_count;
  logic [PW-1:0] w_fill_slot, w_head;
  logic [IW:0]   w_idx;
  logic [IW-1:0] iss_idx;
  logic          iss_uf_q, iss_uf, iss_pop;
  logic          fill_we, fill_wfill, commit_ok;
  logic [IW-1:0] fill_widx;
  logic [WW-1:0] w_rdat;
  w_state_t      w_state;

  assign buffer_w_full = (w_count == CW'(NSLOT));
  assign commit_ok     = buffer_w_commit && !buffer_w_full;
  assign w_state_dbg   = w_state;

  // Fill port decode: nextburst beats next; everything ignored while full.
  always_comb begin
    fill_we    = 1'b0;
    fill_wfill = 1'b0;
    fill_widx  = '0;
    if (!buffer_w_full) begin
      if (buffer_w_nextburst) begin
        fill_we    = 1'b1;
        fill_wfill = 1'b1;
      end else if (buffer_w_next && (w_idx < (IW+1)'(BURST))) begin
        fill_we   = 1'b1;
        fill_widx = w_idx[IW-1:0];
      end
    end
  end

  // Fill word index and fill slot pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_idx       <= '0;
      w_fill_slot <= '0;
    end else begin
      if (fill_we) w_idx <= fill_wfill ? (IW+1)'(1) : w_idx + 1'b1;
      if (commit_ok) w_fill_slot <= w_fill_slot + 1'b1;
    end
  end

  // Underflow is decided on word 0 of each issued burst and held for the rest.
  assign iss_uf  = (iss_idx == '0) ? (w_count == '0) : iss_uf_q;
  assign iss_pop = op_write && (iss_idx == IW'(BURST - 1)) && !iss_uf;

  hpdmc_burst_slots #(.W(WW), .BURST(BURST), .NSLOT(NSLOT)) u_wr_slots (
    .clk      (clk),
    .rst      (rst),
    .we       (fill_we),
    .wslot    (w_fill_slot),
    .widx     (fill_widx),
    .wdat     ({buffer_w_mask, buffer_w_dat}),
    .wfill    (fill_wfill),
    .fill_dat ({{MW{1'b1}}, {DW{1'b0}}}),
    .rslot    (w_head),
    .ridx     (iss_idx),
    .rdat     (w_rdat),
    .inc      (commit_ok),
    .dec      (iss_pop),
    .count    (w_count)
  );

  // Write issue FSM with registered PHY outputs (one cycle after op_write).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_state      <= W_IDLE;
      phy_wr_valid <= 1'b0;
      phy_wr_dat   <= '0;
      phy_wr_mask  <= '1;
      iss_idx      <= '0;
      iss_uf_q     <= 1'b0;
      w_head       <= '0;
    end else if (op_write) begin
      w_state      <= W_RUN;
      phy_wr_valid <= 1'b1;
      if (iss_uf) begin
        phy_wr_dat  <= '0;
        phy_wr_mask <= '1;
      end else begin
        phy_wr_dat  <= w_rdat[DW-1:0];
        phy_wr_mask <= w_rdat[WW-1:DW];
      end
      iss_uf_q <= iss_uf;
      iss_idx  <= iss_idx + 1'b1;
      if (iss_pop) w_head <= w_head + 1'b1;
    end else begin
      w_state      <= W_IDLE;
      phy_wr_valid <= 1'b0;
      phy_wr_dat   <= '0;
      phy_wr_mask  <= '1;
      iss_idx      <= '0;
    end
  end

  // ---------------- read side ----------------
  logic [CW-1:0] r_count;
  logic [PW-1:0] r_cap_slot, r_head;
  logic [IW-1:0] cap_idx, r_idx;
  logic          cap_drop_q, cap_drop, cap_we, cap_done, r_pop;

  assign cap_drop       = (cap_idx == '0) ? (r_count == CW'(NSLOT)) : cap_drop_q;
  assign cap_we         = phy_rd_valid && !cap_drop;
  assign cap_done       = cap_we && (cap_idx == IW'(BURST - 1));
  assign buffer_r_ready = (r_count != '0);
  assign r_pop          = buffer_r_nextburst && buffer_r_ready;

  hpdmc_burst_slots #(.W(DW), .BURST(BURST), .NSLOT(NSLOT)) u_rd_slots (
    .clk      (clk),
    .rst      (rst),
    .we       (cap_we),
    .wslot    (r_cap_slot),
    .widx     (cap_idx),
    .wdat     (phy_rd_dat),
    .wfill    (1'b0),
    .fill_dat ('0),
    .rslot    (r_head),
    .ridx     (r_idx),
    .rdat     (buffer_r_dat),
    .inc      (cap_done),
    .dec      (r_pop),
    .count    (r_count)
  );

  // Capture pointers: a burst that starts while all slots are ready is dropped whole.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cap_idx    <= '0;
      cap_drop_q <= 1'b0;
      r_cap_slot <= '0;
    end else if (phy_rd_valid) begin
      cap_idx    <= cap_idx + 1'b1;
      cap_drop_q <= cap_drop;
      if (cap_done) r_cap_slot <= r_cap_slot + 1'b1;
    end
  end

  // Consume pointers: nextburst releases the head and rewinds; next walks the burst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head <= '0;
      r_idx  <= '0;
    end else if (buffer_r_nextburst) begin
      r_idx <= '0;
      if (r_pop) r_head <= r_head + 1'b1;
    end else if (buffer_r_next) begin
      r_idx <= r_idx + 1'b1;
    end
  end

`ifdef HPDMC_BURST_DATAPATH_ERR_EN
  logic uf_evt, ov_evt;
  assign uf_evt = op_write && (iss_idx == '0) && (w_count == '0);
  assign ov_evt = phy_rd_valid && (cap_idx == '0) && (r_count == CW'(NSLOT));

  // Sticky error flags; a new event wins over err_clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_w_underflow <= 1'b0;
      err_r_overflow  <= 1'b0;
    end else begin
      if (uf_evt)         err_w_underflow <= 1'b1;
      else if (err_clear) err_w_underflow <= 1'b0;
      if (ov_evt)         err_r_overflow  <= 1'b1;
      else if (err_clear) err_r_overflow  <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_hpdmc_burst_datapath.sv
// Bench for hpdmc_burst_datapath (DW=64, BURST=4, NSLOT=2): table-driven write
// bursts, hand-written multi-cycle sequences and randomized traffic checked
// against queue-based reference models.
module tb_hpdmc_burst_datapath;

  localparam int DW = 64, MW = 8, BURST = 4, NSLOT = 2;

  typedef logic [63:0] d4_t [4];
  typedef logic [7:0]  m4_t [4];

  typedef struct {
    logic [63:0] d [6];
    logic [7:0]  m [6];
    int          nw;
    logic [63:0] ed [4];
    logic [7:0]  em [4];
  } wvec_t;

  logic          clk, rst;
  logic          buffer_w_nextburst, buffer_w_next, buffer_w_commit, buffer_w_full;
  logic [MW-1:0] buffer_w_mask;
  logic [DW-1:0] buffer_w_dat;
  logic          op_write, phy_wr_valid;
  logic [DW-1:0] phy_wr_dat;
  logic [MW-1:0] phy_wr_mask;
  logic          phy_rd_valid;
  logic [DW-1:0] phy_rd_dat;
  logic          buffer_r_ready, buffer_r_next, buffer_r_nextburst;
  logic [DW-1:0] buffer_r_dat;
  logic          w_state_dbg;
`ifdef HPDMC_BURST_DATAPATH_ERR_EN
  logic          err_w_underflow, err_r_overflow, err_clear;
`endif

  int total = 0;
  int bad   = 0;

  hpdmc_burst_datapath #(.DW(DW), .BURST(BURST), .NSLOT(NSLOT)) dut (
    .clk                (clk),
    .rst                (rst),
    .buffer_w_nextburst (buffer_w_nextburst),
    .buffer_w_next      (buffer_w_next),
    .buffer_w_mask      (buffer_w_mask),
    .buffer_w_dat       (buffer_w_dat),
    .buffer_w_commit    (buffer_w_commit),
    .buffer_w_full      (buffer_w_full),
    .op_write           (op_write),
    .phy_wr_valid       (phy_wr_valid),
    .phy_wr_dat         (phy_wr_dat),
    .phy_wr_mask        (phy_wr_mask),
    .phy_rd_valid       (phy_rd_valid),
    .phy_rd_dat         (phy_rd_dat),
    .buffer_r_ready     (buffer_r_ready),
    .buffer_r_next      (buffer_r_next),
    .buffer_r_nextburst (buffer_r_nextburst),
    .buffer_r_dat       (buffer_r_dat),
`ifdef HPDMC_BURST_DATAPATH_ERR_EN
    .err_w_underflow    (err_w_underflow),
    .err_r_overflow     (err_r_overflow),
    .err_clear          (err_clear),
`endif
    .w_state_dbg        (w_state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    bad++;
    $display("FAIL watchdog: time limit reached, total=%0d", total);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // ---------------- driver tasks ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    buffer_w_nextburst = 0; buffer_w_next = 0; buffer_w_commit = 0;
    buffer_w_mask = '0; buffer_w_dat = '0; op_write = 0;
    phy_rd_valid = 0; phy_rd_dat = '0; buffer_r_next = 0; buffer_r_nextburst = 0;
`ifdef HPDMC_BURST_DATAPATH_ERR_EN
    err_clear = 0;
`endif
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    step();
    step();
    rst = 0;
    step();
  endtask

  task automatic wr_word(input bit first, input logic [63:0] d, input logic [7:0] m);
    buffer_w_nextburst = first;
    buffer_w_next = !first;
    buffer_w_dat = d;
    buffer_w_mask = m;
    step();
    buffer_w_nextburst = 0;
    buffer_w_next = 0;
  endtask

  task automatic commit();
    buffer_w_commit = 1;
    step();
    buffer_w_commit = 0;
  endtask

  task automatic rd_word(input logic [63:0] d);
    phy_rd_valid = 1;
    phy_rd_dat = d;
    step();
    phy_rd_valid = 0;
  endtask

  // Hold op_write for one burst and compare each issued word; dat checked for ncare words.
  task automatic issue_check(input string tag, input d4_t ed, input m4_t em, input int ncare);
    op_write = 1;
    for (int k = 0; k < BURST; k++) begin
      step();
      chk($sformatf("%s_valid%0d", tag, k), phy_wr_valid, 1);
      chk($sformatf("%s_mask%0d", tag, k), phy_wr_mask, em[k]);
      if (k < ncare) chk($sformatf("%s_dat%0d", tag, k), phy_wr_dat, ed[k]);
    end
    op_write = 0;
    step();
    chk({tag, "_valid_off"}, phy_wr_valid, 0);
    chk({tag, "_mask_off"}, phy_wr_mask, 8'hFF);
  endtask

  // ---------------- scoreboards / models ----------------
  logic [63:0] wq_d[$];
  logic [7:0]  wq_m[$];
  int          wq_n[$];
  logic [63:0] rdq[$];
  logic [63:0] exp_q[$];
  logic [63:0] cap_buf [4];

  wvec_t tbl [4];

  initial begin
    d4_t ed;
    m4_t em;
    int  nw, cap_n, ridx, sz0, ncare;
    bit  cap_drop, v, nx, nb;
    logic [63:0] d;

    rst = 0;
    idle_inputs();

    // Reset state.
    do_reset();
    chk("rst_wr_valid", phy_wr_valid, 0);
    chk("rst_wr_dat", phy_wr_dat, 0);
    chk("rst_wr_mask", phy_wr_mask, 8'hFF);
    chk("rst_w_full", buffer_w_full, 0);
    chk("rst_r_ready", buffer_r_ready, 0);
    chk("rst_state", w_state_dbg, 0);

    // Table: fill pattern -> issued words.
    tbl[0].d  = '{64'h1111111111111111, 64'h2222222222222222, 64'h3333333333333333,
                  64'h4444444444444444, 64'h0, 64'h0};
    tbl[0].m  = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    tbl[0].nw = 4;
    tbl[0].ed = '{64'h1111111111111111, 64'h2222222222222222, 64'h3333333333333333,
                  64'h4444444444444444};
    tbl[0].em = '{8'h00, 8'h00, 8'h00, 8'h00};
    tbl[1].d  = '{64'hAAAAAAAA55555555, 64'h0, 64'h0, 64'h0, 64'h0, 64'h0};
    tbl[1].m  = '{8'h0F, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    tbl[1].nw = 1;
    tbl[1].ed = '{64'hAAAAAAAA55555555, 64'h0, 64'h0, 64'h0};
    tbl[1].em = '{8'h0F, 8'hFF, 8'hFF, 8'hFF};
    tbl[2].d  = '{64'h0101, 64'h0202, 64'h0303, 64'h0404, 64'h0505, 64'h0606};
    tbl[2].m  = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    tbl[2].nw = 6;
    tbl[2].ed = '{64'h0101, 64'h0202, 64'h0303, 64'h0404};
    tbl[2].em = '{8'h01, 8'h02, 8'h03, 8'h04};
    tbl[3].d  = '{64'h5A5A5A5A5A5A5A5A, 64'hA5A5A5A5A5A5A5A5, 64'h0, 64'h0, 64'h0, 64'h0};
    tbl[3].m  = '{8'h80, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00};
    tbl[3].nw = 2;
    tbl[3].ed = '{64'h5A5A5A5A5A5A5A5A, 64'hA5A5A5A5A5A5A5A5, 64'h0, 64'h0};
    tbl[3].em = '{8'h80, 8'h01, 8'hFF, 8'hFF};

    for (int t = 0; t < 4; t++) begin
      for (int i = 0; i < tbl[t].nw; i++) wr_word(i == 0, tbl[t].d[i], tbl[t].m[i]);
      commit();
      chk($sformatf("tbl%0d_full_one", t), buffer_w_full, 0);
      issue_check($sformatf("tbl%0d", t), tbl[t].ed, tbl[t].em, (tbl[t].nw < 4) ? tbl[t].nw : 4);
      chk($sformatf("tbl%0d_full_after", t), buffer_w_full, 0);
    end

    // Two committed slots: full, third fill ignored, back-to-back issue.
    for (int b = 0; b < 2; b++) begin
      for (int i = 0; i < BURST; i++) begin
        d = 64'hB000 + 64'(b * 16 + i);
        exp_q.push_back(d);
        wr_word(i == 0, d, 8'h00);
      end
      commit();
    end
    chk("two_full", buffer_w_full, 1);
    wr_word(1, 64'hDEADDEADDEADDEAD, 8'h00);
    commit();
    chk("third_full", buffer_w_full, 1);
    op_write = 1;
    for (int k = 0; k < 2 * BURST; k++) begin
      step();
      chk($sformatf("b2b_valid%0d", k), phy_wr_valid, 1);
      chk($sformatf("b2b_dat%0d", k), phy_wr_dat, exp_q.pop_front());
      chk($sformatf("b2b_mask%0d", k), phy_wr_mask, 8'h00);
      chk($sformatf("b2b_full%0d", k), buffer_w_full, k < BURST - 1);
    end
    op_write = 0;
    step();
    chk("b2b_valid_off", phy_wr_valid, 0);

    // Underflow: no committed slot.
    ed = '{64'h0, 64'h0, 64'h0, 64'h0};
    em = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
    issue_check("uf", ed, em, 4);
`ifdef HPDMC_BURST_DATAPATH_ERR_EN
    chk("uf_err_set", err_w_underflow, 1);
    err_clear = 1;
    step();
    err_clear = 0;
    chk("uf_err_clear", err_w_underflow, 0);
`endif
    chk("uf_full", buffer_w_full, 0);
    wr_word(1, 64'hC0C0C0C0C0C0C0C0, 8'h00);
    commit();
    ed = '{64'hC0C0C0C0C0C0C0C0, 64'h0, 64'h0, 64'h0};
    em = '{8'h00, 8'hFF, 8'hFF, 8'hFF};
    issue_check("after_uf", ed, em, 1);

    // Three read bursts with no consume: third dropped.
    for (int b = 0; b < 3; b++)
      for (int i = 0; i < BURST; i++) rd_word(64'hD000 + 64'(b * 16 + i));
    chk("rd3_ready", buffer_r_ready, 1);
`ifdef HPDMC_BURST_DATAPATH_ERR_EN
    chk("rd3_ovf_err", err_r_overflow, 1);
`endif
    for (int b = 0; b < 2; b++) begin
      for (int i = 0; i < BURST; i++) begin
        chk($sformatf("rd3_b%0d_w%0d", b, i), buffer_r_dat, 64'hD000 + 64'(b * 16 + i));
        buffer_r_next = 1;
        step();
        buffer_r_next = 0;
      end
      chk($sformatf("rd3_wrap%0d", b), buffer_r_dat, 64'hD000 + 64'(b * 16));
      buffer_r_nextburst = 1;
      step();
      buffer_r_nextburst = 0;
    end
    chk("rd3_ready_empty", buffer_r_ready, 0);

    // Randomized write traffic against a queue model.
    do_reset();
    for (int it = 0; it < 60; it++) begin
      if ($urandom_range(0, 2) != 2) begin
        nw = $urandom_range(1, 4);
        for (int i = 0; i < nw; i++) begin
          ed[i] = {$urandom, $urandom};
          em[i] = 8'($urandom);
          wr_word(i == 0, ed[i], em[i]);
        end
        commit();
        if (wq_n.size() < NSLOT) begin
          for (int i = 0; i < BURST; i++) begin
            wq_d.push_back(ed[i]);
            wq_m.push_back((i < nw) ? em[i] : 8'hFF);
          end
          wq_n.push_back(nw);
        end
      end else begin
        if (wq_n.size() == 0) begin
          ed = '{64'h0, 64'h0, 64'h0, 64'h0};
          em = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
          ncare = 4;
        end else begin
          for (int i = 0; i < BURST; i++) begin
            ed[i] = wq_d.pop_front();
            em[i] = wq_m.pop_front();
          end
          ncare = wq_n.pop_front();
        end
        issue_check($sformatf("rw%0d", it), ed, em, ncare);
      end
      chk($sformatf("rw%0d_full", it), buffer_w_full, wq_n.size() == NSLOT);
    end

    // Randomized read traffic against a flat word-queue model.
    do_reset();
    cap_n = 0; cap_drop = 0; ridx = 0;
    for (int c = 0; c < 400; c++) begin
      v  = ($urandom_range(0, 3) != 0);
      nx = ($urandom_range(0, 2) == 0);
      nb = ($urandom_range(0, 5) == 0);
      d  = {$urandom, $urandom};
      phy_rd_valid = v; phy_rd_dat = d;
      buffer_r_next = nx; buffer_r_nextburst = nb;
      @(posedge clk);
      sz0 = rdq.size() / BURST;
      if (nb && sz0 != 0) repeat (BURST) void'(rdq.pop_front());
      if (v) begin
        if (cap_n == 0) cap_drop = (sz0 == NSLOT);
        cap_buf[cap_n] = d;
        cap_n++;
        if (cap_n == BURST) begin
          cap_n = 0;
          if (!cap_drop) for (int i = 0; i < BURST; i++) rdq.push_back(cap_buf[i]);
        end
      end
      if (nb) ridx = 0;
      else if (nx) ridx = (ridx + 1) % BURST;
      #1;
      chk($sformatf("rr%0d_ready", c), buffer_r_ready, rdq.size() != 0);
      if (rdq.size() != 0) chk($sformatf("rr%0d_dat", c), buffer_r_dat, rdq[ridx]);
    end
    idle_inputs();
    step();

    // Reset pulse mid-write and mid-capture.
    do_reset();
    for (int i = 0; i < BURST; i++) wr_word(i == 0, 64'hE0 + 64'(i), 8'h00);
    commit();
    for (int i = 0; i < BURST; i++) rd_word(64'hF0 + 64'(i));
    chk("mid_ready_pre", buffer_r_ready, 1);
    op_write = 1;
    phy_rd_valid = 1;
    phy_rd_dat = 64'h1234;
    step();
    step();
    chk("mid_valid_pre", phy_wr_valid, 1);
    #2;
    rst = 1;
    #1;
    chk("mid_rst_valid", phy_wr_valid, 0);
    chk("mid_rst_ready", buffer_r_ready, 0);
    chk("mid_rst_mask", phy_wr_mask, 8'hFF);
    chk("mid_rst_full", buffer_w_full, 0);
    idle_inputs();
    step();
    rst = 0;
    step();
    for (int i = 0; i < BURST; i++) begin
      ed[i] = 64'h7700 + 64'(i);
      em[i] = 8'(i + 1);
      wr_word(i == 0, ed[i], em[i]);
    end
    commit();
    issue_check("post_rst", ed, em, 4);
    for (int i = 0; i < BURST; i++) rd_word(64'h8800 + 64'(i));
    chk("post_rst_ready", buffer_r_ready, 1);
    for (int i = 0; i < BURST; i++) begin
      chk($sformatf("post_rst_rd%0d", i), buffer_r_dat, 64'h8800 + 64'(i));
      buffer_r_next = 1;
      step();
      buffer_r_next = 0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hpdmc_burst_datapath.md
Name: hpdmc_burst_datapath

Overview:
- Parametrised single-clock successor to the DDR I/O data buffer.
- Buffers whole write bursts (data + byte mask) from the bus side and streams them to an SDR-rate PHY interface.
- Collects read bursts from the PHY into slots and hands them to the bus side.
- Adds configurable width, burst length and slot depth, explicit commit, ready/full flags and underflow/overflow handling.

Parameters:
- DW, 64, data word width in bits (multiple of 8).
- BURST, 4, words per burst (power of two, at least 2).
- NSLOT, 2, burst slots per direction (power of two, at least 2).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- buffer_w_nextburst  in  1  write word 0 of a new burst into the fill slot.
- buffer_w_next  in  1  write the next word of the current burst.
- buffer_w_mask  in  DW/8  byte mask (1 = masked).
- buffer_w_dat  in  DW  write data.
- buffer_w_commit  in  1  fill slot is complete and may be issued.
- buffer_w_full  out  1  no free write slot.
- op_write  in  1  controller issues write data; held BURST*n cycles.
- phy_wr_valid  out  1  write word valid / DQ output enable.
- phy_wr_dat  out  DW  write word to PHY.
- phy_wr_mask  out  DW/8  mask to PHY.
- phy_rd_valid  in  1  read word from PHY valid.
- phy_rd_dat  in  DW  read word from PHY.
- buffer_r_ready  out  1  at least one complete read burst available.
- buffer_r_next  in  1  advance to the next word within the head burst.
- buffer_r_nextburst  in  1  release the head burst and reset the word index to 0.
- buffer_r_dat  out  DW  word at (head slot, word index).

Behaviour:
- Reset: all pointers and counts = 0; phy_wr_valid = 0; phy_wr_dat = 0; phy_wr_mask = all-ones; buffer_w_full = 0; buffer_r_ready = 0. Slot contents are not cleared. Reset mid-burst aborts both directions immediately.
- Write fill:
  - nextburst stores word 0 at the fill slot, sets mask all-ones in words 1..BURST-1, and sets the word index to 1.
  - next stores at the word index, then increments it; writes past BURST-1 are ignored.
  - nextburst has priority over next in the same cycle.
  - commit increments the committed count and advances the fill slot; commit while full is ignored.
  - buffer_w_full = (committed count == NSLOT); fill writes while full are ignored.
- Write issue FSM, states W_IDLE and W_RUN:
  - op_write in cycle t gives phy_wr_valid = 1 in cycle t+1 (one-cycle latency, registered outputs).
  - The issue word index counts 0..BURST-1. On wrap, the head slot is popped (committed count decremented) and the FSM stays in W_RUN if op_write is still high.
  - When op_write falls: phy_wr_valid = 0 next cycle, mask returns to all-ones, FSM goes to W_IDLE, and the word index clears.
  - If op_write arrives with committed count == 0, words are issued with mask all-ones and dat = 0, and no pop occurs (underflow).
  - Commit and pop in the same cycle leave the count unchanged.
- Read capture:
  - Each phy_rd_valid stores phy_rd_dat at (capture slot, capture index).
  - After BURST words the slot becomes complete (ready count incremented) and the capture slot advances.
  - If word 0 arrives while ready count == NSLOT, the entire burst is dropped (overflow).
- Read consume:
  - buffer_r_dat is a combinational read of (head slot, word index).
  - next increments the word index, wrapping modulo BURST.
  - nextburst pops the head when buffer_r_ready = 1 and clears the word index; nextburst takes priority over next.
  - Capture completion and pop in the same cycle leave the ready count unchanged.
  - buffer_r_ready = (ready count != 0).

Optional Feature:
- HPDMC_BURST_DATAPATH_ERR_EN adds outputs err_w_underflow and err_r_overflow, plus input err_clear.
  - The flags are sticky and set in the cycle after the event.
  - err_clear clears them; set has priority over clear.
  - Without the macro, the ports are absent and there is no error logic.

Decomposition:
- Shared include file with the encodings for W_IDLE and W_RUN and clog2-derived pointer widths.
- One natural sub-module, hpdmc_burst_slots: an NSLOT x BURST register array with write port, read port and a slot count. It is instantiated once per direction.

Test Plan:
1. DW=64, BURST=4, NSLOT=2. nextburst dat 0x11..11, then next x3 with 0x22, 0x33, 0x44, mask 0x00, then commit; op_write held 4 cycles.
   Required: phy_wr_valid high for cycles 1-4 with dat 0x11, 0x22, 0x33, 0x44 and mask 0x00; then low; buffer_w_full = 0.
2. nextburst with mask 0x0F and no next, commit, op_write 4 cycles.
   Required: words 1-3 carry mask 0xFF.
3. Commit 2 slots.
   Required: buffer_w_full = 1; a third nextburst is ignored. op_write for 8 cycles issues both bursts back-to-back, and full drops after the first pop.
4. op_write with no committed slot.
   Required: 4 words with mask 0xFF; err_w_underflow = 1 when the macro is enabled.
5. Three read bursts of phy_rd_valid with no consume.
   Required: buffer_r_ready = 1; third burst dropped; after two nextbursts, ready = 0 and data matches bursts 1 and 2.
6. rst pulse mid-write and mid-capture.
   Required: phy_wr_valid = 0 and ready = 0 immediately; a fresh burst afterwards is correct.
